// File: rtl/mem_arbiter.sv
// Two-port byte-memory arbiter: instruction fetch (read-only) and data port share one memory.
// Ties go to the port that did not own last; a waiting port caps the owner at MAX_BEATS bytes.
module mem_arbiter #(
    parameter int MAX_BEATS = 4,
    parameter int AW        = 32
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          I_REQ,
    input  logic [AW-1:0] I_ADDR,
    output logic          I_GNT,
    output logic          I_RDY,
    output logic [7:0]    I_RDATA,
    input  logic          D_REQ,
    input  logic          D_WE,
    input  logic [AW-1:0] D_ADDR,
    input  logic [7:0]    D_WDATA,
    output logic          D_GNT,
    output logic          D_RDY,
    output logic [7:0]    D_RDATA,
    output logic          M_EN,
    output logic          M_WE,
    output logic [AW-1:0] M_ADDR,
    output logic [7:0]    M_WDATA,
    input  logic [7:0]    M_RDATA,
    input  logic          M_ACK
);

    localparam int CW = $clog2(MAX_BEATS + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BEATS);

    typedef enum logic [1:0] {IDLE, OWN_I, OWN_D, GAP} state_t;

    state_t        state_q, state_d;
    logic          last_d_q, last_d_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] cnt_adv;
    logic          own_i, own_d, rdy;

    always_comb begin
        own_i   = (state_q == OWN_I);
        own_d   = (state_q == OWN_D);
        I_GNT   = own_i;
        D_GNT   = own_d;
        M_EN    = (own_i & I_REQ) | (own_d & D_REQ);
        M_WE    = own_d & D_WE;
        M_ADDR  = own_i ? I_ADDR : (own_d ? D_ADDR : '0);
        M_WDATA = own_d ? D_WDATA : 8'h00;
        // An ACK arriving after the owner withdrew is dropped because M_EN is already low
        rdy     = M_ACK & M_EN;
        I_RDY   = own_i & rdy;
        D_RDY   = own_d & rdy;
        I_RDATA = M_RDATA;
        D_RDATA = M_RDATA;
    end

    always_comb begin
        state_d  = state_q;
        last_d_d = last_d_q;
        cnt_d    = cnt_q;
        cnt_adv  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
        case (state_q)
            IDLE, GAP: begin
                cnt_d = '0;
                if (I_REQ && D_REQ) state_d = last_d_q ? OWN_I : OWN_D;
                else if (I_REQ)     state_d = OWN_I;
                else if (D_REQ)     state_d = OWN_D;
                else                state_d = IDLE;
            end
            OWN_I: begin
                if (rdy) cnt_d = cnt_adv;
                if (!I_REQ || (D_REQ && rdy && cnt_adv == CNT_MAX)) begin
                    state_d  = GAP;
                    last_d_d = 1'b0;
                end
            end
            OWN_D: begin
                if (rdy) cnt_d = cnt_adv;
                if (!D_REQ || (I_REQ && rdy && cnt_adv == CNT_MAX)) begin
                    state_d  = GAP;
                    last_d_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            last_d_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            last_d_q <= last_d_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: solo access, tie-break, fairness cap, write path, abort and reset.
module tb_mem_arbiter;

    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_req, d_req, d_we, m_ack;
    logic [AW-1:0] i_addr, d_addr;
    logic [7:0]    d_wdata, m_rdata;
    logic          i_gnt, i_rdy, d_gnt, d_rdy, m_en, m_we;
    logic [7:0]    i_rdata, d_rdata, m_wdata;
    logic [AW-1:0] m_addr;

    int n_checks = 0;
    int n_pass   = 0;

    mem_arbiter #(.MAX_BEATS(4), .AW(AW)) dut (
        .CLK(clk), .RST(rst),
        .I_REQ(i_req), .I_ADDR(i_addr), .I_GNT(i_gnt), .I_RDY(i_rdy), .I_RDATA(i_rdata),
        .D_REQ(d_req), .D_WE(d_we), .D_ADDR(d_addr), .D_WDATA(d_wdata),
        .D_GNT(d_gnt), .D_RDY(d_rdy), .D_RDATA(d_rdata),
        .M_EN(m_en), .M_WE(m_we), .M_ADDR(m_addr), .M_WDATA(m_wdata),
        .M_RDATA(m_rdata), .M_ACK(m_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Inputs change 1ns after the rising edge; checks follow 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk_gnt(input string tag, input logic ig, input logic dg);
        chk({tag, "_ignt"}, 32'(i_gnt), 32'(ig));
        chk({tag, "_dgnt"}, 32'(d_gnt), 32'(dg));
    endtask

    // Expected {I_GNT, D_GNT, I_RDY, D_RDY} per cycle with both ports requesting and ACK every cycle
    logic [3:0] fair_exp [12];
    initial begin
        fair_exp[0]  = 4'b0000;
        fair_exp[1]  = 4'b0101;
        fair_exp[2]  = 4'b0101;
        fair_exp[3]  = 4'b0101;
        fair_exp[4]  = 4'b0101;
        fair_exp[5]  = 4'b0000;
        fair_exp[6]  = 4'b1010;
        fair_exp[7]  = 4'b1010;
        fair_exp[8]  = 4'b1010;
        fair_exp[9]  = 4'b1010;
        fair_exp[10] = 4'b0000;
        fair_exp[11] = 4'b0101;
    end

    initial begin
        int d_beats;
        rst = 1'b1; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; m_ack = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = 8'h00; m_rdata = 8'h00;
        tick(); tick();
        settle();
        chk_gnt("reset", 1'b0, 1'b0);
        chk("reset_men", 32'(m_en), 32'd0);
        chk("reset_mwe", 32'(m_we), 32'd0);
        rst = 1'b0;

        // Solo instruction fetch with ACK two cycles after grant
        i_req = 1'b1; i_addr = 32'h100;
        settle();
        chk("solo_c0_ignt", 32'(i_gnt), 32'd0);
        tick(); settle();
        chk_gnt("solo_c1", 1'b1, 1'b0);
        chk("solo_c1_men", 32'(m_en), 32'd1);
        chk("solo_c1_maddr", m_addr, 32'h100);
        chk("solo_c1_mwe", 32'(m_we), 32'd0);
        chk("solo_c1_irdy", 32'(i_rdy), 32'd0);
        tick(); settle();
        chk("solo_c2_irdy", 32'(i_rdy), 32'd0);
        tick();
        m_ack = 1'b1; m_rdata = 8'h5A;
        settle();
        chk("solo_c3_irdy", 32'(i_rdy), 32'd1);
        chk("solo_c3_drdy", 32'(d_rdy), 32'd0);
        chk("solo_c3_irdata", 32'(i_rdata), 32'h5A);
        tick();
        m_ack = 1'b0;
        settle();
        chk("solo_c4_irdy", 32'(i_rdy), 32'd0);
        i_req = 1'b0;
        tick(); tick();

        // Tie right after reset goes to D; releasing D gives one GAP then I
        rst = 1'b1; tick(); rst = 1'b0;
        i_req = 1'b1; d_req = 1'b1; i_addr = 32'h200; d_addr = 32'h300;
        tick(); settle();
        chk_gnt("tie", 1'b0, 1'b1);
        chk("tie_maddr", m_addr, 32'h300);
        d_req = 1'b0;
        settle();
        chk("tie_drop_men", 32'(m_en), 32'd0);
        tick(); settle();
        chk_gnt("tie_gap", 1'b0, 1'b0);
        chk("tie_gap_maddr", m_addr, 32'h0);
        tick(); settle();
        chk_gnt("tie_after", 1'b1, 1'b0);
        i_req = 1'b0;
        tick(); tick();

        // Fairness cap: last owner is I, so D starts; ACK in IDLE must be ignored
        i_req = 1'b1; d_req = 1'b1; m_ack = 1'b1;
        d_beats = 0;
        for (int k = 0; k < 12; k++) begin
            if (k > 0) tick();
            settle();
            chk($sformatf("fair_c%0d", k), 32'({i_gnt, d_gnt, i_rdy, d_rdy}), 32'(fair_exp[k]));
            if (k < 6 && d_rdy) d_beats++;
        end
        chk("fair_d_beats", 32'(d_beats), 32'd4);
        i_req = 1'b0; d_req = 1'b0; m_ack = 1'b0;
        tick(); tick();

        // Write path, then I owns while D_WE is still high
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 8'hA5;
        tick(); settle();
        chk("wr_dgnt", 32'(d_gnt), 32'd1);
        chk("wr_mwe", 32'(m_we), 32'd1);
        chk("wr_maddr", m_addr, 32'h20);
        chk("wr_mwdata", 32'(m_wdata), 32'hA5);
        d_req = 1'b0; i_req = 1'b1; i_addr = 32'h44;
        tick(); tick(); settle();
        chk_gnt("rdonly", 1'b1, 1'b0);
        chk("rdonly_mwe", 32'(m_we), 32'd0);
        chk("rdonly_maddr", m_addr, 32'h44);
        chk("rdonly_mwdata", 32'(m_wdata), 32'h0);

        // Abort: owner drops REQ, ACK arrives late
        i_req = 1'b0; m_ack = 1'b1;
        settle();
        chk("abort_irdy", 32'(i_rdy), 32'd0);
        chk("abort_drdy", 32'(d_rdy), 32'd0);
        tick(); settle();
        chk("abort_gap_irdy", 32'(i_rdy), 32'd0);
        chk("abort_gap_drdy", 32'(d_rdy), 32'd0);
        m_ack = 1'b0; d_we = 1'b0;
        tick(); tick();

        // Solo D holds grant beyond the cap, then yields at the next RDY once I asks
        d_req = 1'b1; m_ack = 1'b1;
        for (int k = 0; k < 6; k++) tick();
        settle();
        chk_gnt("sat", 1'b0, 1'b1);
        chk("sat_drdy", 32'(d_rdy), 32'd1);
        i_req = 1'b1;
        tick(); settle();
        chk_gnt("sat_yield_gap", 1'b0, 1'b0);
        tick(); settle();
        chk_gnt("sat_yield_i", 1'b1, 1'b0);

        // Reset mid-burst with ACK in the same cycle; last owner returns to I
        rst = 1'b1;
        tick();
        rst = 1'b0;
        settle();
        chk_gnt("rst_mid", 1'b0, 1'b0);
        chk("rst_mid_men", 32'(m_en), 32'd0);
        chk("rst_mid_mwe", 32'(m_we), 32'd0);
        chk("rst_mid_irdy", 32'(i_rdy), 32'd0);
        tick(); settle();
        chk_gnt("rst_tie", 1'b0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
